// File: rtl/tbb_if.sv
// Host-side request/response bundle of the task batch buffer.
//   ReqValid/ReqLineIdx : line request toward the host (driven by tbb)
//   ReqAck              : host accepts the pending request
//   RspValid/RspLineIdx/RspData : returned line, any order
// Modports: master = tbb side, slave = host side.
interface tbb_if #(
   parameter int unsigned TBB_ADDR_WIDTH = 8,
   parameter int unsigned TBB_DATA_WIDTH = 512
);
   logic                      ReqValid;
   logic [TBB_ADDR_WIDTH-1:0] ReqLineIdx;
   logic                      ReqAck;
   logic                      RspValid;
   logic [TBB_ADDR_WIDTH-1:0] RspLineIdx;
   logic [TBB_DATA_WIDTH-1:0] RspData;

   modport master (
      output ReqValid, ReqLineIdx,
      input  ReqAck, RspValid, RspLineIdx, RspData
   );

   modport slave (
      input  ReqValid, ReqLineIdx,
      output ReqAck, RspValid, RspLineIdx, RspData
   );
endinterface

// File: rtl/tbb.sv
// Task batch buffer: fetches one batch of NUM_LINES lines from the host into a RAM,
// then exposes the whole batch to a PE array for random-access reads.
// Ports:
//   clk, reset_n : core clock, asynchronous active-low reset
//   Start        : fetch a new batch (honoured only when idle)
//   Release      : PE done with the batch (honoured only when ready)
//   Full, Empty  : batch resident / buffer idle
//   RdAddr       : PE read address; RdDout is the registered read data (1-cycle latency)
//   host         : request/ack/response bundle toward the host (tbb_if.master)
module tbb #(
   parameter int unsigned TBB_ADDR_WIDTH = 8,
   parameter int unsigned TBB_DATA_WIDTH = 512
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      Start,
   input  logic                      Release,
   output logic                      Full,
   output logic                      Empty,
   input  logic [TBB_ADDR_WIDTH-1:0] RdAddr,
   output logic [TBB_DATA_WIDTH-1:0] RdDout,
   tbb_if.master                     host
);

   localparam int unsigned NumLines = 1 << TBB_ADDR_WIDTH;
   localparam logic [TBB_ADDR_WIDTH-1:0] ReqOne = 1;
   localparam logic [TBB_ADDR_WIDTH:0]   RspOne = 1;

   typedef enum logic [1:0] {StIdle, StFetch, StWait, StReady} stateT;

   stateT                     stateQ, stateD;
   logic [TBB_ADDR_WIDTH-1:0] reqCntQ, reqCntD;
   logic [TBB_ADDR_WIDTH:0]   rspCntQ, rspCntD;
   logic                      memWe;

   logic [TBB_DATA_WIDTH-1:0] mem [NumLines];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stateQ  <= StIdle;
         reqCntQ <= '0;
         rspCntQ <= '0;
      end else begin
         stateQ  <= stateD;
         reqCntQ <= reqCntD;
         rspCntQ <= rspCntD;
      end
   end

   always_comb begin
      stateD  = stateQ;
      reqCntD = reqCntQ;
      rspCntD = rspCntQ;
      memWe   = 1'b0;
      unique case (stateQ)
         StIdle: begin
            if (Start) begin
               stateD  = StFetch;
               reqCntD = '0;
               rspCntD = '0;
            end
         end
         StFetch: begin
            if (host.ReqAck) begin
               // Counter wraps to 0 on the last line, leaving it clean for the next batch.
               reqCntD = reqCntQ + ReqOne;
               if (&reqCntQ) begin
                  stateD = StWait;
               end
            end
            if (host.RspValid) begin
               memWe   = 1'b1;
               rspCntD = rspCntQ + RspOne;
            end
         end
         StWait: begin
            if (host.RspValid) begin
               memWe   = 1'b1;
               rspCntD = rspCntQ + RspOne;
               // Count never exceeds NUM_LINES, so the MSB alone marks "all lines in".
               if (rspCntD[TBB_ADDR_WIDTH]) begin
                  stateD = StReady;
               end
            end
         end
         StReady: begin
            if (Release) begin
               stateD = StIdle;
            end
         end
         default: stateD = StIdle;
      endcase
   end

   // RAM write port: not reset, contents are undefined after reset.
   always_ff @(posedge clk) begin
      if (memWe) begin
         mem[host.RspLineIdx] <= host.RspData;
      end
   end

   // Read port runs every cycle; a same-address write in the same cycle returns old data.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         RdDout <= '0;
      end else begin
         RdDout <= mem[RdAddr];
      end
   end

   assign host.ReqValid   = (stateQ == StFetch);
   assign host.ReqLineIdx = reqCntQ;
   assign Full            = (stateQ == StReady);
   assign Empty           = (stateQ == StIdle);

endmodule

// File: tb/tb_tbb.sv
// Testbench for tbb with 4-line batches: a batch-level model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_tbb;
   localparam int unsigned AW = 2;
   localparam int unsigned DW = 512;
   localparam int unsigned N  = 4;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          Start = 1'b0;
   logic          Release = 1'b0;
   logic          Full, Empty;
   logic [AW-1:0] RdAddr = '0;
   logic [DW-1:0] RdDout;

   tbb_if #(.TBB_ADDR_WIDTH(AW), .TBB_DATA_WIDTH(DW)) hif ();

   tbb #(.TBB_ADDR_WIDTH(AW), .TBB_DATA_WIDTH(DW)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .Start   (Start),
      .Release (Release),
      .Full    (Full),
      .Empty   (Empty),
      .RdAddr  (RdAddr),
      .RdDout  (RdDout),
      .host    (hif)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Batch-level model: a batch is either absent, in flight (counting requests and
   // responses), or held; RAM is a plain array of the lines received.
   bit            mActive = 1'b0;
   bit            mHeld = 1'b0;
   int            mReq = 0;
   int            mRsp = 0;
   logic [DW-1:0] mRam [N];
   bit            expRdValid = 1'b1;
   logic [DW-1:0] expRd = '0;
   int            nReq, nRsp;

   assign nReq = mReq + ((hif.ReqAck && mReq < N) ? 1 : 0);
   assign nRsp = mRsp + (hif.RspValid ? 1 : 0);

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mActive    <= 1'b0;
         mHeld      <= 1'b0;
         mReq       <= 0;
         mRsp       <= 0;
         expRdValid <= 1'b1;
         expRd      <= '0;
      end else begin
         expRdValid <= mHeld;
         expRd      <= mRam[RdAddr];
         if (!mActive) begin
            if (Start) begin
               mActive <= 1'b1;
               mReq    <= 0;
               mRsp    <= 0;
            end
         end else if (mHeld) begin
            if (Release) begin
               mActive <= 1'b0;
               mHeld   <= 1'b0;
            end
         end else begin
            if (hif.RspValid) mRam[hif.RspLineIdx] <= hif.RspData;
            mReq  <= nReq;
            mRsp  <= nRsp;
            mHeld <= (nReq == N) && (nRsp == N);
         end
      end
   end

   // Per-cycle comparison against the model, 1 time unit after the active edge.
   always @(posedge clk) begin
      bit expRv;
      #1;
      expRv = mActive && !mHeld && (mReq < N);
      check("m_empty", Empty, !mActive);
      check("m_full", Full, mHeld);
      check("m_reqvalid", hif.ReqValid, expRv);
      if (expRv) check("m_reqidx", hif.ReqLineIdx, mReq);
      if (expRdValid) check("m_rddout", RdDout, expRd);
   end

   task automatic setIn(input bit st, input bit ack, input bit rv, input int ri,
                        input logic [DW-1:0] rd, input bit rel, input int ra);
      Start          = st;
      hif.ReqAck     = ack;
      hif.RspValid   = rv;
      hif.RspLineIdx = AW'(ri);
      hif.RspData    = rd;
      Release        = rel;
      RdAddr         = AW'(ra);
   endtask

   // In-order fill from IDLE: acks held high, each response two cycles after its ack.
   task automatic fillInOrder(input logic [DW-1:0] base);
      for (int k = 0; k <= 7; k++) begin
         @(negedge clk);
         if (k == 0) check("fill_idle", Empty, 1'b1);
         if (k == 1) check("fill_emptyfall", Empty, 1'b0);
         if (k >= 1 && k <= 4) begin
            check("fill_rv", hif.ReqValid, 1'b1);
            check("fill_idx", hif.ReqLineIdx, k - 1);
         end
         if (k == 6) check("fill_notfull", Full, 1'b0);
         if (k == 7) check("fill_full", Full, 1'b1);
         setIn(k == 0, k >= 1 && k <= 4, k >= 3 && k <= 6, k - 3, base + k - 3, 1'b0, 0);
      end
   endtask

   task automatic readAll(input logic [DW-1:0] base);
      for (int k = 0; k <= 4; k++) begin
         @(negedge clk);
         if (k >= 1) check("read_data", RdDout, base + k - 1);
         setIn(1'b0, 1'b0, 1'b0, 0, '0, 1'b0, (k < 4) ? k : 0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int li [4];
      setIn(1'b0, 1'b0, 1'b0, 0, '0, 1'b0, 0);
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_reqvalid", hif.ReqValid, 1'b0);
      check("rst_reqidx", hif.ReqLineIdx, 0);
      check("rst_full", Full, 1'b0);
      check("rst_empty", Empty, 1'b1);
      check("rst_rddout", RdDout, '0);
      reset_n = 1'b1;

      // In-order fill and readback.
      fillInOrder('hA0);
      readAll('hA0);

      // Release and Start together in READY: only the Release takes effect.
      @(negedge clk);
      setIn(1'b1, 1'b0, 1'b0, 0, '0, 1'b1, 0);
      @(negedge clk);
      check("coll_empty", Empty, 1'b1);
      check("coll_full", Full, 1'b0);
      check("coll_rv", hif.ReqValid, 1'b0);
      setIn(1'b1, 1'b0, 1'b0, 0, '0, 1'b0, 0);
      @(negedge clk);
      check("restart_rv", hif.ReqValid, 1'b1);
      check("restart_idx", hif.ReqLineIdx, 0);
      // Start while fetching is ignored.
      setIn(1'b1, 1'b0, 1'b0, 0, '0, 1'b0, 0);
      @(negedge clk);
      check("fetchstart_idx", hif.ReqLineIdx, 0);
      check("fetchstart_rv", hif.ReqValid, 1'b1);

      // Out-of-order responses 2,0,3,1 with alternating ack stalls; Release in WAIT.
      li = '{-1, -1, -1, -1};
      for (int s = 0; s <= 10; s++) begin
         int rl;
         @(negedge clk);
         if (s == 1 || s == 2) check("ooo_hold", hif.ReqLineIdx, 1);
         if (s == 3) check("ooo_idx2", hif.ReqLineIdx, 2);
         if (s == 7) check("ooo_wait_rv", hif.ReqValid, 1'b0);
         if (s == 7 || s == 8) check("ooo_notfull", Full, 1'b0);
         if (s == 8) check("ooo_relwait", Empty, 1'b0);
         if (s == 9 || s == 10) check("ooo_full", Full, 1'b1);
         rl = (s == 5) ? 2 : (s == 6) ? 0 : (s == 7) ? 3 : (s == 8) ? 1 : -1;
         setIn(s == 1 || s == 3 || s == 9, (s % 2 == 0) && s <= 6, rl >= 0, (rl >= 0) ? rl : 0,
               'hB0 + ((rl >= 0) ? rl : 0), s == 7, 0);
      end
      readAll('hB0);

      // Release, then a stray response in IDLE, then a fresh fill.
      @(negedge clk);
      setIn(1'b0, 1'b0, 1'b0, 0, '0, 1'b1, 0);
      @(negedge clk);
      check("rel_empty", Empty, 1'b1);
      setIn(1'b0, 1'b0, 1'b1, 1, 'hFF, 1'b0, 0);
      @(negedge clk);
      setIn(1'b0, 1'b0, 1'b0, 0, '0, 1'b0, 0);
      fillInOrder('h10);
      readAll('h10);
      @(negedge clk);
      setIn(1'b0, 1'b0, 1'b0, 0, '0, 1'b1, 0);
      @(negedge clk);
      setIn(1'b0, 1'b0, 1'b0, 0, '0, 1'b0, 0);

      // Reset after two acks, late responses, then a normal fill.
      @(negedge clk);
      setIn(1'b1, 1'b0, 1'b0, 0, '0, 1'b0, 0);
      @(negedge clk);
      setIn(1'b0, 1'b1, 1'b0, 0, '0, 1'b0, 0);
      @(negedge clk);
      setIn(1'b0, 1'b1, 1'b0, 0, '0, 1'b0, 0);
      @(negedge clk);
      setIn(1'b0, 1'b0, 1'b0, 0, '0, 1'b0, 0);
      reset_n = 1'b0;
      #1;
      check("mrst_rv", hif.ReqValid, 1'b0);
      check("mrst_empty", Empty, 1'b1);
      check("mrst_full", Full, 1'b0);
      @(negedge clk);
      reset_n = 1'b1;
      setIn(1'b0, 1'b0, 1'b1, 0, 'hEE, 1'b0, 0);
      @(negedge clk);
      setIn(1'b0, 1'b0, 1'b1, 1, 'hEE, 1'b0, 0);
      @(negedge clk);
      check("late_empty", Empty, 1'b1);
      check("late_rv", hif.ReqValid, 1'b0);
      setIn(1'b0, 1'b0, 1'b0, 0, '0, 1'b0, 0);
      fillInOrder('hC0);
      readAll('hC0);
      @(negedge clk);
      setIn(1'b0, 1'b0, 1'b0, 0, '0, 1'b1, 0);
      @(negedge clk);
      setIn(1'b0, 1'b0, 1'b0, 0, '0, 1'b0, 0);
      @(negedge clk);
      check("end_empty", Empty, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
